piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts the word out one bit per clock on a single serial line, with frame markers. It is the transmit end of the serial bit stream that the team's D-flip-flop-based capture and shift registers receive. It sits between a parallel data source and any single-bit serial consumer.

---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 77 +++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with frame markers
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    piso_serializer_if.slave  bus
);
    localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             first, first_n;
    logic             ready;
    logic             accept;

    // Ready while idle or while the last bit is on the line, so frames can abut.
    assign ready  = (state == IDLE) || (cnt == '0);
    assign accept = bus.load_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            first <= first_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        first_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                    shreg_n = bus.load_data;
                    cnt_n   = CNT_TOP;
                    first_n = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_n   = cnt - 1'b1;
                    shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                end else if (accept) begin
                    shreg_n = bus.load_data;
                    cnt_n   = CNT_TOP;
                    first_n = 1'b1;
                end else begin
                    state_n = IDLE;
                    shreg_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.load_ready  = ready;
    assign bus.ser_valid   = (state == SHIFT);
    assign bus.busy        = (state == SHIFT);
    assign bus.ser_out     = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign bus.frame_start = (state == SHIFT) && first;
    assign bus.frame_end   = (state == SHIFT) && (cnt == '0);
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer in three configurations
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       lv    [3];
    logic [7:0] ld    [3];
    logic       o_ser [3];
    logic       o_val [3];
    logic       o_fs  [3];
    logic       o_fe  [3];
    logic       o_busy[3];
    logic       o_rdy [3];

    piso_serializer_if #(.WIDTH(8)) bus0 ();
    piso_serializer_if #(.WIDTH(8)) bus1 ();
    piso_serializer_if #(.WIDTH(1)) bus2 ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    assign bus0.load_valid = lv[0];
    assign bus0.load_data  = ld[0];
    assign bus1.load_valid = lv[1];
    assign bus1.load_data  = ld[1];
    assign bus2.load_valid = lv[2];
    assign bus2.load_data  = ld[2][0:0];

    assign o_ser[0] = bus0.ser_out;  assign o_val[0] = bus0.ser_valid;  assign o_fs[0] = bus0.frame_start;
    assign o_fe[0]  = bus0.frame_end; assign o_busy[0] = bus0.busy;     assign o_rdy[0] = bus0.load_ready;
    assign o_ser[1] = bus1.ser_out;  assign o_val[1] = bus1.ser_valid;  assign o_fs[1] = bus1.frame_start;
    assign o_fe[1]  = bus1.frame_end; assign o_busy[1] = bus1.busy;     assign o_rdy[1] = bus1.load_ready;
    assign o_ser[2] = bus2.ser_out;  assign o_val[2] = bus2.ser_valid;  assign o_fs[2] = bus2.frame_start;
    assign o_fe[2]  = bus2.frame_end; assign o_busy[2] = bus2.busy;     assign o_rdy[2] = bus2.load_ready;

    // Reference: each accepted word becomes a list of expected line cycles.
    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } bit_t;

    bit_t mq [3][$];
    int   wid [3] = '{8, 8, 1};
    bit   msb [3] = '{1'b1, 1'b0, 1'b1};
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic push_word(input int d, input logic [7:0] w);
        for (int i = 0; i < wid[d]; i++) begin
            int   idx;
            bit_t e;
            idx = msb[d] ? (wid[d] - 1 - i) : i;
            e.b = w[idx];
            e.s = (i == 0);
            e.e = (i == wid[d] - 1);
            mq[d].push_back(e);
        end
    endtask

    task automatic check_outputs(input int d);
        bit_t h;
        logic act;
        act = (mq[d].size() > 0);
        h   = act ? mq[d][0] : '0;
        chk("ser_valid",   d, {7'd0, o_val[d]},  {7'd0, act});
        chk("busy",        d, {7'd0, o_busy[d]}, {7'd0, act});
        chk("ser_out",     d, {7'd0, o_ser[d]},  {7'd0, h.b});
        chk("frame_start", d, {7'd0, o_fs[d]},   {7'd0, h.s});
        chk("frame_end",   d, {7'd0, o_fe[d]},   {7'd0, h.e});
        chk("load_ready",  d, {7'd0, o_rdy[d]},  {7'd0, (mq[d].size() <= 1)});
    endtask

    // Called just after a falling edge: check, drive, then advance the model over the next rising edge.
    task automatic step(input int d, input logic v, input logic [7:0] w);
        logic rdy;
        check_outputs(d);
        rdy   = (mq[d].size() <= 1);
        lv[d] = v;
        ld[d] = w;
        if (mq[d].size() > 0) void'(mq[d].pop_front());
        if (v && rdy) push_word(d, w);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        for (int d = 0; d < 3; d++) lv[d] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            check_outputs(d);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_outputs(d);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            lv[d] = 1'b0;
            ld[d] = 8'h00;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_outputs(d);
        rst_n = 1'b1;

        // Single word MSB first, then idle.
        step(0, 1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 8'h00);

        // Mid-cycle asynchronous reset while idle.
        mid_reset();

        // Held valid with changing data during bits 1..7, 3C taken at the last bit.
        step(0, 1'b1, 8'hA5);
        for (int i = 0; i < 7; i++) step(0, 1'b1, 8'($urandom));
        step(0, 1'b1, 8'h3C);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 8'h00);

        // Reset during bit 3 of FF, then a clean 81 frame.
        step(0, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h00);
        mid_reset();
        step(0, 1'b1, 8'h81);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 8'h00);

        // LSB first.
        step(1, 1'b1, 8'h01);
        for (int i = 0; i < 10; i++) step(1, 1'b0, 8'h00);

        // WIDTH=1 back-to-back.
        step(2, 1'b1, 8'h01);
        step(2, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step(2, 1'b0, 8'h00);

        // Randomized traffic on every configuration.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 150; i++) step(d, ($urandom_range(0, 3) != 0), 8'($urandom));
            for (int i = 0; i < 10; i++) step(d, 1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
